// File: rtl/led_string_pkg.sv
// Shared types, FSM encoding and default bit timing for the one-wire LED string driver.
// Every timing constant is a count of wb_clk_i cycles.
package led_string_pkg;

  localparam int PIXEL_W        = 24;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_T0H_CYC    = 14;
  localparam int DEF_T1H_CYC    = 28;
  localparam int DEF_BIT_CYC    = 50;
  localparam int DEF_RESET_CYC  = 2000;

  // Wire order is G, R, B with the MSB of G leaving first.
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } led_state_e;

endpackage

// File: rtl/led_string_driver_if.sv
// Pixel/latch handshake between the register block (master) and the LED string driver (slave).
// A pixel moves on valid & ready; latch_i is a single-cycle pulse with no handshake.
interface led_string_driver_if;
  import led_string_pkg::*;

  logic   pix_valid_i;
  pixel_t pix_data_i;
  logic   pix_ready_o;
  logic   latch_i;

  modport master (output pix_valid_i, output pix_data_i, output latch_i, input pix_ready_o);
  modport slave  (input pix_valid_i, input pix_data_i, input latch_i, output pix_ready_o);

endinterface

// File: rtl/led_pixel_fifo.sv
// Generic synchronous FIFO (power-of-two depth) with a combinational head and a registered level.
// Latency: a push is visible at the head one cycle later. Backpressure: push ignored when full, pop ignored when empty.
module led_pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge wb_clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/led_string_driver.sv
// Serialises buffered GRB pixels onto a WS2812-style one-wire line, then a latch gap; LED_DONE_IRQ_EN adds done_irq_o.
// Latency: push -> LOAD next cycle -> led_o high the cycle after. Backpressure: pix_ready_o low while the FIFO is full.
module led_string_driver
  import led_string_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int T0H_CYC    = DEF_T0H_CYC,
  parameter int T1H_CYC    = DEF_T1H_CYC,
  parameter int BIT_CYC    = DEF_BIT_CYC,
  parameter int RESET_CYC  = DEF_RESET_CYC
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  led_string_driver_if.slave              pix_if,
  output logic                            led_o,
  output logic                            busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_o,
  output logic                            underrun_o
`ifdef LED_DONE_IRQ_EN
  ,
  output logic                            done_irq_o
`endif
);

  localparam int CNT_W = $clog2(BIT_CYC);
  localparam int GAP_W = $clog2(RESET_CYC);
  localparam logic [CNT_W-1:0] T0H_L    = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] T1H_L    = CNT_W'(T1H_CYC);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RESET_CYC - 1);

  led_state_e         state_q;
  led_state_e         state_d;
  logic [PIXEL_W-1:0] shift_q;
  logic [4:0]         bit_idx_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               latch_pending_q;
  logic               underrun_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic [PIXEL_W-1:0] fifo_head;
  logic               load_pix;
  logic               bit_adv;
  logic               gap_done;
  logic               underrun_set;
  logic               bit_end;

  led_pixel_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .push     (pix_if.pix_valid_i),
    .push_dat (pix_if.pix_data_i),
    .pop      (load_pix),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level_o)
  );

  assign pix_if.pix_ready_o = ~fifo_full;
  assign bit_end            = (bit_cnt_q == BIT_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Popping in the final cycle of bit 0 keeps consecutive pixels gap-free.
  always_comb begin
    state_d      = state_q;
    load_pix     = 1'b0;
    bit_adv      = 1'b0;
    gap_done     = 1'b0;
    underrun_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty)          state_d = ST_LOAD;
        else if (latch_pending_q) state_d = ST_LATCH;
      end
      ST_LOAD: begin
        load_pix = 1'b1;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_end) begin
          if (bit_idx_q != '0)      bit_adv = 1'b1;
          else if (!fifo_empty)     load_pix = 1'b1;
          else if (latch_pending_q) state_d = ST_LATCH;
          else begin
            underrun_set = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      ST_LATCH: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      shift_q         <= '0;
      bit_idx_q       <= '0;
      bit_cnt_q       <= '0;
      gap_cnt_q       <= '0;
      latch_pending_q <= 1'b0;
      underrun_q      <= 1'b0;
    end else begin
      underrun_q <= underrun_set;
      if (load_pix) begin
        shift_q   <= fifo_head;
        bit_idx_q <= 5'(PIXEL_W - 1);
        bit_cnt_q <= '0;
      end else if (bit_adv) begin
        shift_q   <= {shift_q[PIXEL_W-2:0], 1'b0};
        bit_idx_q <= bit_idx_q - 5'd1;
        bit_cnt_q <= '0;
      end else if (state_q == ST_SHIFT) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
      if (state_q == ST_LATCH) gap_cnt_q <= gap_cnt_q + GAP_W'(1);
      else                     gap_cnt_q <= '0;
      // A latch request arriving while one is pending merges into the same gap.
      if (gap_done)            latch_pending_q <= 1'b0;
      else if (pix_if.latch_i) latch_pending_q <= 1'b1;
    end
  end

  assign led_o      = (state_q == ST_SHIFT) &&
                      (bit_cnt_q < (shift_q[PIXEL_W-1] ? T1H_L : T0H_L));
  assign busy_o     = (state_q != ST_IDLE);
  assign underrun_o = underrun_q;

`ifdef LED_DONE_IRQ_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) done_irq_o <= 1'b0;
    else          done_irq_o <= gap_done;
  end
`endif

endmodule

// File: tb/tb_led_string_driver.sv
// Bench for led_string_driver: decodes led_o pulse widths back into pixels and scores them against the pushed stream.
// Frame timing, underrun, latch-gap and reset behaviour are checked against cycle counts derived from the bit timing.
module tb_led_string_driver;
  import led_string_pkg::*;

  localparam int T0H     = 14;
  localparam int T1H     = 28;
  localparam int BITC    = 50;
  localparam int RSTC    = 2000;
  localparam int DEPTH   = 8;
  localparam int PIX_CYC = 24 * BITC;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       led_o;
  logic       busy_o;
  logic       underrun_o;
  logic [3:0] fifo_level_o;
`ifdef LED_DONE_IRQ_EN
  logic       done_irq_o;
`endif

  led_string_driver_if pif ();

  led_string_driver #(
    .FIFO_DEPTH (DEPTH),
    .T0H_CYC    (T0H),
    .T1H_CYC    (T1H),
    .BIT_CYC    (BITC),
    .RESET_CYC  (RSTC)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .pix_if       (pif),
    .led_o        (led_o),
    .busy_o       (busy_o),
    .fifo_level_o (fifo_level_o),
    .underrun_o   (underrun_o)
`ifdef LED_DONE_IRQ_EN
    ,
    .done_irq_o   (done_irq_o)
`endif
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  int          cyc      = 0;
  int          n_chk    = 0;
  int          n_fail   = 0;
  logic [23:0] exp_q[$];
  int          start_q[$];
  int          und_n    = 0;
  int          und_last = -1;
  int          hi_total = 0;
  logic        prev_led = 1'b0;
  int          hi_len   = 0;
  int          lo_len   = 0;
  int          nbits    = 0;
  logic [23:0] sr       = '0;

  always @(posedge wb_clk_i) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Line decoder: each high pulse is one bit, 24 bits make one pixel popped from the scoreboard.
  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      prev_led = 1'b0;
      nbits    = 0;
      hi_len   = 0;
      lo_len   = 0;
    end else begin
      if (led_o === 1'b1) begin
        hi_total++;
        if (!prev_led) begin
          if (nbits != 0) chk("bit_slot_len", hi_len + lo_len, BITC);
          else            start_q.push_back(cyc);
          hi_len = 1;
          lo_len = 0;
        end else begin
          hi_len++;
        end
      end else begin
        if (prev_led) begin
          chk("pulse_width", hi_len, (hi_len > (T0H + T1H) / 2) ? T1H : T0H);
          sr = {sr[22:0], (hi_len > (T0H + T1H) / 2)};
          nbits++;
          if (nbits == 24) begin
            nbits = 0;
            if (exp_q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_pixel: got 0x%0h, required no pixel (cycle %0d)", sr, cyc);
            end else begin
              chk("pixel_data", sr, exp_q.pop_front());
            end
          end
        end
        lo_len++;
      end
      prev_led = (led_o === 1'b1);
    end
  end

  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && underrun_o === 1'b1) begin
      und_n++;
      und_last = cyc;
    end
  end

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge wb_clk_i);
  endtask

  task automatic push_pix(input logic [23:0] d, input logic lat, output int t);
    int w;
    w = 0;
    pif.pix_valid_i = 1'b1;
    pif.pix_data_i  = d;
    pif.latch_i     = lat;
    while (pif.pix_ready_o !== 1'b1 && w < 5000) begin
      @(negedge wb_clk_i);
      pif.latch_i = 1'b0;
      w++;
    end
    chk("push_ready_wait", w < 5000, 1);
    if (w < 5000) begin
      @(posedge wb_clk_i);
      exp_q.push_back(d);
    end
    @(negedge wb_clk_i);
    pif.pix_valid_i = 1'b0;
    pif.latch_i     = 1'b0;
    t = cyc;
  endtask

  task automatic pulse_latch(output int t);
    pif.latch_i = 1'b1;
    @(negedge wb_clk_i);
    pif.latch_i = 1'b0;
    t = cyc;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int w;
    int quiet;
    w = 0;
    quiet = 0;
    while (quiet < 4 && w < budget) begin
      @(negedge wb_clk_i);
      w++;
      if (busy_o === 1'b0 && fifo_level_o == 4'd0 && exp_q.size() == 0) quiet++;
      else quiet = 0;
    end
    chk(name, w < budget, 1);
  endtask

  // One 0xA50000 pixel with a simultaneous latch: pixel, then the gap, then idle.
  task automatic frame_a50000(input string tag);
    int t;
    int s;
    int hi0;
    int und0;
    start_q.delete();
    hi0  = hi_total;
    und0 = und_n;
    push_pix(24'hA50000, 1'b1, t);
    s = t + 2;
    at_cyc(t + 1);
    chk({tag, "_load_busy"}, busy_o, 1);
    chk({tag, "_load_led"}, led_o, 0);
    at_cyc(s);
    chk({tag, "_first_rise"}, led_o, 1);
    at_cyc(s + PIX_CYC + RSTC - 1);
    chk({tag, "_gap_end_busy"}, busy_o, 1);
    chk({tag, "_gap_led"}, led_o, 0);
    at_cyc(s + PIX_CYC + RSTC);
    chk({tag, "_idle_busy"}, busy_o, 0);
`ifdef LED_DONE_IRQ_EN
    chk({tag, "_done_pulse"}, done_irq_o, 1);
    at_cyc(s + PIX_CYC + RSTC + 1);
    chk({tag, "_done_clear"}, done_irq_o, 0);
`endif
    chk({tag, "_starts"}, start_q.size(), 1);
    if (start_q.size() > 0) chk({tag, "_start_cycle"}, start_q[0], s);
    chk({tag, "_high_cycles"}, hi_total - hi0, 4 * T1H + 20 * T0H);
    chk({tag, "_no_underrun"}, und_n - und0, 0);
  endtask

  initial begin
    int t;
    int t2;
    int s;
    int hi0;
    int und0;
    int n_acc;
    int w;
    logic        acc;
    logic [23:0] d;

    pif.pix_valid_i = 1'b0;
    pif.pix_data_i  = '0;
    pif.latch_i     = 1'b0;
    wb_rst_i        = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    chk("reset_led", led_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_level", fifo_level_o, 0);
    chk("reset_ready", pif.pix_ready_o, 1);
    chk("reset_underrun", underrun_o, 0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // Test 1
    frame_a50000("t1");

    // Test 2: all-ones then all-zeros pixel, contiguous, then underrun
    start_q.delete();
    hi0  = hi_total;
    und0 = und_n;
    push_pix(24'hFFFFFF, 1'b0, t);
    push_pix(24'h000000, 1'b0, t2);
    s = t + 2;
    at_cyc(s + 2 * PIX_CYC + 2);
    chk("t2_starts", start_q.size(), 2);
    if (start_q.size() == 2) begin
      chk("t2_start0", start_q[0], s);
      chk("t2_start1_contiguous", start_q[1], s + PIX_CYC);
    end
    chk("t2_high_cycles", hi_total - hi0, 24 * T1H + 24 * T0H);
    chk("t2_underrun_count", und_n - und0, 1);
    chk("t2_underrun_cycle", und_last, s + 2 * PIX_CYC);
    chk("t2_busy", busy_o, 0);

    // Test 3: hold valid with incrementing data
    d = 24'h100000;
    n_acc = 0;
    pif.pix_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pif.pix_data_i = d;
      acc = pif.pix_ready_o;
      @(posedge wb_clk_i);
      if (acc) begin
        exp_q.push_back(d);
        d++;
        n_acc++;
      end
      @(negedge wb_clk_i);
    end
    chk("t3_accepted_before_full", n_acc, 9);
    chk("t3_level_full", fifo_level_o, DEPTH);
    chk("t3_ready_low_when_full", pif.pix_ready_o, 0);
    w = 0;
    while (n_acc < 12 && w < 8000) begin
      pif.pix_data_i = d;
      acc = pif.pix_ready_o;
      @(posedge wb_clk_i);
      if (acc) begin
        exp_q.push_back(d);
        d++;
        n_acc++;
      end
      @(negedge wb_clk_i);
      w++;
    end
    pif.pix_valid_i = 1'b0;
    chk("t3_refill", n_acc, 12);
    pulse_latch(t);
    wait_idle(20000, "t3_drain_timeout");
    chk("t3_scoreboard_empty", exp_q.size(), 0);

    // Test 4: single pixel, no latch
    start_q.delete();
    und0 = und_n;
    push_pix(24'($urandom), 1'b0, t);
    s = t + 2;
    at_cyc(s + PIX_CYC + 1);
    chk("t4_underrun_count", und_n - und0, 1);
    chk("t4_underrun_cycle", und_last, s + PIX_CYC);
    chk("t4_led_low", led_o, 0);
    chk("t4_busy", busy_o, 0);
    if (start_q.size() > 0) chk("t4_start", start_q[0], s);

    // Test 5: reset during bit 5 with a second pixel queued
    und0 = und_n;
    push_pix(24'h123456, 1'b0, t);
    push_pix(24'hABCDEF, 1'b0, t2);
    s = t + 2;
    at_cyc(s + 5 * BITC + 10);
    chk("t5_led_mid_bit", led_o, 1);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    chk("t5_rst_led", led_o, 0);
    chk("t5_rst_level", fifo_level_o, 0);
    chk("t5_rst_ready", pif.pix_ready_o, 1);
    chk("t5_rst_busy", busy_o, 0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge wb_clk_i);
    chk("t5_no_underrun", und_n - und0, 0);
    frame_a50000("t5");

    // Test 6: bare latch, second latch absorbed
    hi0 = hi_total;
    pulse_latch(t);
    chk("t6_pending_busy", busy_o, 0);
    at_cyc(t + 1);
    chk("t6_gap_busy_first", busy_o, 1);
    at_cyc(t + 500);
    pulse_latch(t2);
    at_cyc(t + RSTC);
    chk("t6_gap_busy_last", busy_o, 1);
    at_cyc(t + RSTC + 1);
    chk("t6_idle_after_gap", busy_o, 0);
`ifdef LED_DONE_IRQ_EN
    chk("t6_done_pulse", done_irq_o, 1);
`endif
    at_cyc(t + RSTC + 50);
    chk("t6_no_second_gap", busy_o, 0);
    chk("t6_led_low_in_gap", hi_total - hi0, 0);

    // Randomised stream with sporadic latches
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 800)) @(negedge wb_clk_i);
      push_pix(24'($urandom), ($urandom_range(0, 3) == 0), t);
    end
    pulse_latch(t);
    wait_idle(30000, "rand_drain_timeout");
    chk("rand_scoreboard_empty", exp_q.size(), 0);
    chk("rand_decoder_aligned", nbits, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got no end of test, required completion within 95000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
